// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave to native register-bus bridge. The read and write engines
// run independently; the bridge decodes a base/span window and times out reads.
module axil_native_bridge #(
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = '0,
  parameter longint unsigned          SPAN_BYTES     = 'h1000,
  parameter int unsigned              TIMEOUT_CYCLES = 64
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic [2:0]                AXI_AWPROT,
  input  logic                      AXI_AWVALID,
  output logic                      AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                      AXI_WVALID,
  output logic                      AXI_WREADY,
  output logic [1:0]                AXI_BRESP,
  output logic                      AXI_BVALID,
  input  logic                      AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
  input  logic [2:0]                AXI_ARPROT,
  input  logic                      AXI_ARVALID,
  output logic                      AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     AXI_RDATA,
  output logic [1:0]                AXI_RRESP,
  output logic                      AXI_RVALID,
  input  logic                      AXI_RREADY,
  output logic                      WEN,
  output logic [ADDR_WIDTH-1:0]     WADDR,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WBE,
  output logic                      WACK,
  output logic                      REN,
  output logic [ADDR_WIDTH-1:0]     RADDR,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic                      RVALID
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned LSB      = $clog2(STRB_W);
  localparam int unsigned TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMR_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [ADDR_WIDTH:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_SPAN = (ADDR_WIDTH+1)'(SPAN_BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  logic unused_prot;
  assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

  // Subtracting in ADDR_WIDTH+1 bits: the top bit flags addr < BASE_ADDR,
  // and the low bits are the window offset, so there is no wrap-around.
  logic [ADDR_WIDTH:0]   aw_diff, ar_diff;
  logic                  aw_hit, ar_hit;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;

  always_comb begin
    aw_diff = {1'b0, AXI_AWADDR} - WIN_LO;
    ar_diff = {1'b0, AXI_ARADDR} - WIN_LO;
    aw_hit  = !aw_diff[ADDR_WIDTH] && (aw_diff < WIN_SPAN);
    ar_hit  = !ar_diff[ADDR_WIDTH] && (ar_diff < WIN_SPAN);
    aw_off  = aw_diff[ADDR_WIDTH-1:0];
    ar_off  = ar_diff[ADDR_WIDTH-1:0];
    aw_off[LSB-1:0] = '0;
    ar_off[LSB-1:0] = '0;
  end

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                  aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d;
  logic                  whit_q, whit_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wbe_q, wbe_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs;

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    whit_d    = whit_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wbe_d     = wbe_q;
    bresp_d   = bresp_q;
    aw_hs     = AXI_AWVALID && aw_rdy_q;
    w_hs      = AXI_WVALID && w_rdy_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = aw_off;
          whit_d   = aw_hit;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = AXI_WDATA;
          wbe_d   = AXI_WSTRB;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_EXEC;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      W_EXEC: begin
        bresp_d   = whit_q ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readiness is registered: it reflects where the engine will be next cycle.
    aw_rdy_d = (w_state_d == W_IDLE) && !aw_got_d;
    w_rdy_d  = (w_state_d == W_IDLE) && !w_got_d;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      whit_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_rdy_q  <= aw_rdy_d;
      w_rdy_q   <= w_rdy_d;
      whit_q    <= whit_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      bresp_q   <= bresp_d;
    end
  end

  assign AXI_AWREADY = aw_rdy_q;
  assign AXI_WREADY  = w_rdy_q;
  assign AXI_BVALID  = (w_state_q == W_RESP);
  assign AXI_BRESP   = bresp_q;
  assign WEN         = (w_state_q == W_EXEC) && whit_q;
  assign WADDR       = waddr_q;
  assign WDATA       = wdata_q;
  assign WBE         = wbe_q;
  assign WACK        = (w_state_q == W_RESP) && AXI_BREADY && whit_q;

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  ar_rdy_q, ar_rdy_d;
  logic                  ren_done_q, ren_done_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs;

  always_comb begin
    r_state_d  = r_state_q;
    ren_done_d = ren_done_q;
    tmr_d      = tmr_q;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_hs      = AXI_ARVALID && ar_rdy_q;
    case (r_state_q)
      R_IDLE: begin
        tmr_d      = '0;
        ren_done_d = 1'b0;
        if (ar_hs) begin
          raddr_d = ar_off;
          if (ar_hit) begin
            r_state_d = R_WAIT;
          end else begin
            rdata_d   = '0;
            rresp_d   = RESP_SLVERR;
            r_state_d = R_RESP;
          end
        end
      end
      R_WAIT: begin
        ren_done_d = 1'b1;
        // Native data takes priority over a timeout expiring in the same cycle.
        if (RVALID) begin
          rdata_d   = RDATA;
          rresp_d   = RESP_OKAY;
          r_state_d = R_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (tmr_q == TMR_W'(TMR_LAST))) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      R_RESP: begin
        if (AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_rdy_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_state_q  <= R_IDLE;
      ar_rdy_q   <= 1'b0;
      ren_done_q <= 1'b0;
      tmr_q      <= '0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_rdy_q   <= ar_rdy_d;
      ren_done_q <= ren_done_d;
      tmr_q      <= tmr_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign AXI_ARREADY = ar_rdy_q;
  assign AXI_RVALID  = (r_state_q == R_RESP);
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign REN         = (r_state_q == R_WAIT) && !ren_done_q;
  assign RADDR       = raddr_q;

endmodule

// File: tb/tb_axil_native_bridge.sv
// Directed bench for axil_native_bridge: write/read paths, decode miss,
// read timeout, concurrent channels and asynchronous reset.
module tb_axil_native_bridge;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          AXI_ACLK, AXI_ARESETN;
  logic [AW-1:0] AXI_AWADDR, AXI_ARADDR;
  logic [2:0]    AXI_AWPROT, AXI_ARPROT;
  logic          AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [DW-1:0] AXI_WDATA, AXI_RDATA;
  logic [3:0]    AXI_WSTRB;
  logic [1:0]    AXI_BRESP, AXI_RRESP;
  logic          AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
  logic          AXI_RVALID, AXI_RREADY;
  logic          WEN, WACK, REN, RVALID;
  logic [AW-1:0] WADDR, RADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WBE;

  int n_chk = 0;
  int n_err = 0;
  int wen_cnt = 0, ren_cnt = 0, wack_cnt = 0;
  int wen0, ren0, wack0;

  axil_native_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(32'h0),
    .SPAN_BYTES(64'h1000), .TIMEOUT_CYCLES(8)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .WBE(WBE), .WACK(WACK),
    .REN(REN), .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID)
  );

  initial begin
    AXI_ACLK = 1'b0;
    forever #5 AXI_ACLK = ~AXI_ACLK;
  end

  always @(posedge AXI_ACLK) begin
    if (WEN)  wen_cnt++;
    if (REN)  ren_cnt++;
    if (WACK) wack_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge; checks follow #1 later.
  task automatic tick();
    @(posedge AXI_ACLK);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".awready"}, AXI_AWREADY, 0);
    chk({tag, ".wready"},  AXI_WREADY, 0);
    chk({tag, ".arready"}, AXI_ARREADY, 0);
    chk({tag, ".bvalid"},  AXI_BVALID, 0);
    chk({tag, ".bresp"},   AXI_BRESP, 0);
    chk({tag, ".rvalid"},  AXI_RVALID, 0);
    chk({tag, ".rresp"},   AXI_RRESP, 0);
    chk({tag, ".rdata"},   AXI_RDATA, 0);
    chk({tag, ".wen"},     WEN, 0);
    chk({tag, ".waddr"},   WADDR, 0);
    chk({tag, ".wdata"},   WDATA, 0);
    chk({tag, ".wbe"},     WBE, 0);
    chk({tag, ".wack"},    WACK, 0);
    chk({tag, ".ren"},     REN, 0);
    chk({tag, ".raddr"},   RADDR, 0);
  endtask

  initial begin
    AXI_ARESETN = 1'b0;
    AXI_AWADDR = '0; AXI_AWPROT = '0; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = '0; AXI_ARPROT = '0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b0;
    RDATA = '0; RVALID = 1'b0;

    // Reset state
    #1 chk_all_zero("reset");
    tick(); tick();
    AXI_ARESETN = 1'b1;
    tick(); #1;
    chk("post_rst.awready", AXI_AWREADY, 1);
    chk("post_rst.wready",  AXI_WREADY, 1);
    chk("post_rst.arready", AXI_ARREADY, 1);

    // 1: AW 0x10, W two cycles later
    wen0 = wen_cnt; wack0 = wack_cnt;
    AXI_AWADDR = 32'h10; AXI_AWVALID = 1'b1;
    tick(); AXI_AWVALID = 1'b0; #1;
    chk("t1.awready_drop", AXI_AWREADY, 0);
    chk("t1.wready_hold", AXI_WREADY, 1);
    tick();
    AXI_WDATA = 32'hDEADBEEF; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    tick(); AXI_WVALID = 1'b0; #1;
    chk("t1.wen", WEN, 1);
    chk("t1.waddr", WADDR, 32'h10);
    chk("t1.wdata", WDATA, 32'hDEADBEEF);
    chk("t1.wbe", WBE, 4'hF);
    tick(); #1;
    chk("t1.wen_once", WEN, 0);
    chk("t1.bvalid", AXI_BVALID, 1);
    chk("t1.bresp", AXI_BRESP, 2'b00);
    AXI_BREADY = 1'b1; #1;
    chk("t1.wack", WACK, 1);
    tick(); AXI_BREADY = 1'b0; #1;
    chk("t1.bvalid_drop", AXI_BVALID, 0);
    chk("t1.awready_back", AXI_AWREADY, 1);
    chk("t1.wen_count", wen_cnt - wen0, 1);
    chk("t1.wack_count", wack_cnt - wack0, 1);

    // 2: W before AW, WSTRB 0x3, BREADY low 5 cycles
    wen0 = wen_cnt;
    AXI_WDATA = 32'hCAFEF00D; AXI_WSTRB = 4'h3; AXI_WVALID = 1'b1;
    tick(); AXI_WVALID = 1'b0; #1;
    chk("t2.wready_drop", AXI_WREADY, 0);
    chk("t2.awready_hold", AXI_AWREADY, 1);
    AXI_AWADDR = 32'h24; AXI_AWVALID = 1'b1;
    tick(); AXI_AWVALID = 1'b0; #1;
    chk("t2.wen", WEN, 1);
    chk("t2.waddr", WADDR, 32'h24);
    chk("t2.wdata", WDATA, 32'hCAFEF00D);
    chk("t2.wbe", WBE, 4'h3);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2.bvalid_held", AXI_BVALID, 1);
      chk("t2.bresp_stable", AXI_BRESP, 2'b00);
      tick();
    end
    AXI_BREADY = 1'b1; #1;
    chk("t2.bvalid_last", AXI_BVALID, 1);
    chk("t2.wack", WACK, 1);
    tick(); AXI_BREADY = 1'b0; #1;
    chk("t2.bvalid_drop", AXI_BVALID, 0);
    chk("t2.wen_count", wen_cnt - wen0, 1);

    // 3: decode miss at 0x1000, write then read
    wen0 = wen_cnt; wack0 = wack_cnt; ren0 = ren_cnt;
    AXI_AWADDR = 32'h1000; AXI_AWVALID = 1'b1;
    AXI_WDATA = 32'h55AA55AA; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    tick(); AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; #1;
    chk("t3.no_wen", WEN, 0);
    tick(); #1;
    chk("t3.bvalid", AXI_BVALID, 1);
    chk("t3.bresp_slverr", AXI_BRESP, 2'b10);
    AXI_BREADY = 1'b1; #1;
    chk("t3.no_wack", WACK, 0);
    tick(); AXI_BREADY = 1'b0; #1;
    chk("t3.wen_count", wen_cnt - wen0, 0);
    chk("t3.wack_count", wack_cnt - wack0, 0);
    AXI_ARADDR = 32'h1000; AXI_ARVALID = 1'b1; #1;
    chk("t3.arready", AXI_ARREADY, 1);
    tick(); AXI_ARVALID = 1'b0; #1;
    chk("t3.no_ren", REN, 0);
    chk("t3.rvalid", AXI_RVALID, 1);
    chk("t3.rresp_slverr", AXI_RRESP, 2'b10);
    chk("t3.rdata_zero", AXI_RDATA, 0);
    AXI_RREADY = 1'b1;
    tick(); AXI_RREADY = 1'b0; #1;
    chk("t3.rvalid_drop", AXI_RVALID, 0);
    chk("t3.arready_back", AXI_ARREADY, 1);
    chk("t3.ren_count", ren_cnt - ren0, 0);

    // 4: read 0x20, native answer 3 cycles after REN, RREADY low 2 cycles
    ren0 = ren_cnt;
    AXI_ARADDR = 32'h20; AXI_ARVALID = 1'b1;
    tick(); AXI_ARVALID = 1'b0; #1;
    chk("t4.ren", REN, 1);
    chk("t4.raddr", RADDR, 32'h20);
    chk("t4.arready_drop", AXI_ARREADY, 0);
    tick(); #1;
    chk("t4.ren_once", REN, 0);
    chk("t4.no_rvalid", AXI_RVALID, 0);
    tick(); tick();
    RDATA = 32'h12345678; RVALID = 1'b1;
    tick(); RVALID = 1'b0; RDATA = 32'hFFFFFFFF; #1;
    chk("t4.rvalid", AXI_RVALID, 1);
    chk("t4.rdata", AXI_RDATA, 32'h12345678);
    chk("t4.rresp", AXI_RRESP, 2'b00);
    tick(); #1;
    chk("t4.rvalid_held", AXI_RVALID, 1);
    chk("t4.rdata_stable", AXI_RDATA, 32'h12345678);
    tick(); #1;
    chk("t4.rvalid_held2", AXI_RVALID, 1);
    AXI_RREADY = 1'b1;
    tick(); AXI_RREADY = 1'b0; #1;
    chk("t4.rvalid_drop", AXI_RVALID, 0);
    chk("t4.ren_count", ren_cnt - ren0, 1);

    // 5: native never answers -> SLVERR after 8 wait cycles
    AXI_ARADDR = 32'h30; AXI_ARVALID = 1'b1;
    tick(); AXI_ARVALID = 1'b0; #1;
    chk("t5.ren", REN, 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5.waiting", AXI_RVALID, 0);
      tick();
    end
    #1;
    chk("t5.timeout_rvalid", AXI_RVALID, 1);
    chk("t5.timeout_rresp", AXI_RRESP, 2'b10);
    chk("t5.timeout_rdata", AXI_RDATA, 0);
    RDATA = 32'hAAAA5555; RVALID = 1'b1; AXI_RREADY = 1'b1;
    tick(); AXI_RREADY = 1'b0; #1;
    chk("t5.rvalid_drop", AXI_RVALID, 0);
    tick(); RVALID = 1'b0; #1;
    chk("t5.late_ignored", AXI_RVALID, 0);
    chk("t5.arready", AXI_ARREADY, 1);
    ren0 = ren_cnt;
    AXI_ARADDR = 32'h40; AXI_ARVALID = 1'b1;
    tick(); AXI_ARVALID = 1'b0;
    RDATA = 32'h0BADCAFE; RVALID = 1'b1; #1;
    chk("t5.next_ren", REN, 1);
    chk("t5.next_raddr", RADDR, 32'h40);
    tick(); RVALID = 1'b0; #1;
    chk("t5.next_rvalid", AXI_RVALID, 1);
    chk("t5.next_rdata", AXI_RDATA, 32'h0BADCAFE);
    chk("t5.next_rresp", AXI_RRESP, 2'b00);
    AXI_RREADY = 1'b1;
    tick(); AXI_RREADY = 1'b0; #1;
    chk("t5.next_ren_count", ren_cnt - ren0, 1);

    // 6: concurrent write and read, then reset mid-wait
    AXI_AWADDR = 32'h50; AXI_AWVALID = 1'b1;
    AXI_WDATA = 32'h11223344; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    AXI_ARADDR = 32'h60; AXI_ARVALID = 1'b1;
    tick(); AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0; #1;
    chk("t6.wen", WEN, 1);
    chk("t6.ren", REN, 1);
    chk("t6.raddr", RADDR, 32'h60);
    tick(); #1;
    chk("t6.bvalid", AXI_BVALID, 1);
    AXI_ARESETN = 1'b0; #1;
    chk_all_zero("t6.rst");
    tick(); tick();
    AXI_ARESETN = 1'b1;
    RDATA = 32'h77777777; RVALID = 1'b1;
    tick(); RVALID = 1'b0; #1;
    chk("t6.awready", AXI_AWREADY, 1);
    chk("t6.wready", AXI_WREADY, 1);
    chk("t6.arready", AXI_ARREADY, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t6.no_stale_rvalid", AXI_RVALID, 0);
      chk("t6.no_stale_bvalid", AXI_BVALID, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_native_bridge.md
Name: axil_native_bridge

Overview:
- Parametrised AXI4-Lite slave to native register-bus bridge. Successor to the single-FSM bridge, with the extensions listed below.
- Independent, concurrent read and write engines.
- AW and W accepted in either order.
- Byte-enable forwarding.
- Base/span address decode, with SLVERR on decode miss.
- Read-timeout protection, with SLVERR when the native side never answers.
- Sits between an AXI4-Lite interconnect port and a native register file or peripheral.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; 32 or 64.
- ADDR_WIDTH, 32, AXI and native address width in bits.
- BASE_ADDR, 0, first byte address decoded by this bridge.
- SPAN_BYTES, 'h1000, size of the decoded window in bytes; must be > 0.
- TIMEOUT_CYCLES, 64, maximum cycles spent waiting for RVALID; 0 disables the timeout.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  reset, asynchronous, active-low.
- AXI_AWADDR  in  ADDR_WIDTH  write address.
- AXI_AWPROT  in  3  ignored.
- AXI_AWVALID  in  1 / AXI_AWREADY  out  1  AW handshake.
- AXI_WDATA  in  DATA_WIDTH  write data.
- AXI_WSTRB  in  DATA_WIDTH/8  write strobes.
- AXI_WVALID  in  1 / AXI_WREADY  out  1  W handshake.
- AXI_BRESP  out  2 / AXI_BVALID  out  1 / AXI_BREADY  in  1  write response.
- AXI_ARADDR  in  ADDR_WIDTH  read address.
- AXI_ARPROT  in  3  ignored.
- AXI_ARVALID  in  1 / AXI_ARREADY  out  1  AR handshake.
- AXI_RDATA  out  DATA_WIDTH / AXI_RRESP  out  2 / AXI_RVALID  out  1 / AXI_RREADY  in  1  read response.
- WEN  out  1  one-cycle native write strobe.
- WADDR  out  ADDR_WIDTH  write offset (address minus BASE_ADDR, low log2(DATA_WIDTH/8) bits zeroed).
- WDATA  out  DATA_WIDTH  write data.
- WBE  out  DATA_WIDTH/8  byte enables, equal to the captured AXI_WSTRB.
- WACK  out  1  one-cycle pulse on B handshake of a decoded write.
- REN  out  1  one-cycle native read strobe.
- RADDR  out  ADDR_WIDTH  read offset, formed like WADDR.
- RDATA  in  DATA_WIDTH  native read data.
- RVALID  in  1  native read data valid.

Behaviour:

Reset:
- AXI_ARESETN low asynchronously clears all state. Both FSMs go to IDLE.
- Every output reads 0 while reset is asserted, including AWREADY, WREADY and ARREADY.
- Reset mid-transaction drops the transaction; no WEN, REN, BVALID or RVALID is issued for it.

Decode:
- hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + SPAN_BYTES).
- Compare in ADDR_WIDTH+1 bits so there is no wrap-around at the top of the address space.

Write FSM, states W_IDLE, W_EXEC, W_RESP:
- W_IDLE:
  - AWREADY is high while AW is not yet captured; WREADY is high while W is not yet captured. Both are registered and high from the first cycle after reset release.
  - Each channel is captured on its own handshake and its READY drops the next cycle. AW and W may arrive in the same cycle or in either order.
  - When both are captured, go to W_EXEC.
- W_EXEC (1 cycle):
  - On hit: WEN=1 with WADDR/WDATA/WBE valid in the same cycle; bresp=OKAY (00).
  - On miss: no WEN; bresp=SLVERR (10).
  - Go to W_RESP.
- W_RESP:
  - BVALID is held with BRESP until BREADY.
  - On handshake: BVALID drops next cycle; WACK pulses 1 cycle if the write was a hit; go to W_IDLE.
- Latency: the later of the AW/W handshakes at edge N gives WEN in cycle N+1 and BVALID from cycle N+2.
- WSTRB=0 on a hit still pulses WEN, with WBE=0.

Read FSM, states R_IDLE, R_WAIT, R_RESP:
- R_IDLE:
  - ARREADY is high. On handshake, capture the address and drop ARREADY.
  - Hit: go to R_WAIT. Miss: go to R_RESP with RDATA=0, RRESP=SLVERR, and no REN.
- R_WAIT:
  - REN=1 with RADDR in the first R_WAIT cycle only.
  - RVALID is sampled in every R_WAIT cycle, including the REN cycle.
  - On RVALID: capture RDATA, set RRESP=OKAY, go to R_RESP.
  - A timer counts R_WAIT cycles. If it reaches TIMEOUT_CYCLES (nonzero) without RVALID: RDATA=0, RRESP=SLVERR, go to R_RESP.
  - When RVALID arrives in the same cycle the timeout expires, RVALID wins (OKAY).
- R_RESP:
  - RVALID is held with stable RDATA/RRESP until RREADY.
  - On handshake: RVALID drops next cycle; go to R_IDLE.
- Native RVALID outside R_WAIT is ignored. A late RVALID after a timeout is therefore discarded.
- Latency: AR handshake at edge N gives REN in N+1. RVALID in N+1 gives AXI_RVALID from N+2.

Concurrency:
- The read and write engines are fully independent. WEN and REN may be high in the same cycle.
- No ordering is imposed between the read and write channels.
- Only one outstanding transaction per channel.

Test Plan:
- AW 0x10 then W 0xDEADBEEF/WSTRB 0xF two cycles later -> one WEN, WADDR=0x10, WDATA=0xDEADBEEF, WBE=0xF; BRESP=00; WACK pulse on the B handshake.
- W before AW, WSTRB=0x3, BREADY held low 5 cycles -> BVALID stays high 5 cycles with BRESP stable; exactly one WEN; WBE=0x3.
- Write to 0x1000 with BASE=0, SPAN=0x1000 -> no WEN, BRESP=10, no WACK. Read of 0x1000 -> no REN, RDATA=0, RRESP=10.
- Read 0x20, native RVALID 3 cycles after REN with 0x12345678, RREADY low 2 cycles -> RDATA=0x12345678, RRESP=00, RVALID held until RREADY.
- TIMEOUT_CYCLES=8, native never answers -> RVALID 8 cycles after entering R_WAIT with RRESP=10, RDATA=0; a subsequent read completes normally.
- Write and read issued in the same cycle, then AXI_ARESETN pulsed low mid-R_WAIT -> WEN and REN in the same cycle; on reset all outputs 0 asynchronously; after release AWREADY/WREADY/ARREADY high and no stale RVALID.
